// File: rtl/fairy_sram_arbiter.sv
// fairy_sram_arbiter
// Shares one SRAM port between the instruction-fetch and data-memory
// requesters. One transaction is outstanding at a time. Data requests win
// arbitration, but a streak counter guarantees that a pending fetch is served
// after DATA_MAX_STREAK consecutive data grants.
module fairy_sram_arbiter #(
    parameter int DATA_MAX_STREAK = 4
) (
    input  logic        aclk,
    input  logic        areset_n,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [3:0]  inst_cen,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_ack,
    output logic        inst_rrdy,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_cen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic        data_rrdy,
    output logic [31:0] data_rdata,

    output logic [3:0]  sram_cen,
    output logic        sram_wr,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_ack,
    input  logic        sram_rrdy,
    input  logic [31:0] sram_rdata,

    output logic        arb_busy,
    output logic        arb_owner
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;

    localparam logic [3:0] MAX_STREAK = 4'(DATA_MAX_STREAK);

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    // Streak after a grant: counts data grants that overtook a waiting fetch,
    // saturating at the limit; any other grant restarts the count.
    function automatic logic [3:0] next_streak(
        input logic [3:0] cur,
        input logic       data_granted,
        input logic       inst_pending
    );
        logic [3:0] res;
        if (data_granted && inst_pending) begin
            if (cur >= MAX_STREAK) begin
                res = MAX_STREAK;
            end else begin
                res = cur + 4'd1;
            end
        end else begin
            res = 4'd0;
        end
        return res;
    endfunction

    logic [1:0]  state_r, state_nxt_s;
    logic        owner_r, owner_nxt_s;
    logic        wr_r, wr_nxt_s;
    logic [3:0]  cen_r, cen_nxt_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic [31:0] wdata_r, wdata_nxt_s;
    logic [3:0]  streak_r, streak_nxt_s;

    logic        grant_data_s;
    logic        grant_inst_s;
    logic        ack_s;
    logic        rrdy_s;

    // Arbitration: data wins unless the fetch has waited through a full streak.
    always_comb begin
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
        if (data_req && !(inst_req && (streak_r == MAX_STREAK))) begin
            grant_data_s = 1'b1;
        end else begin
            grant_inst_s = inst_req;
        end
    end

    // Next-state logic for the single-outstanding-transaction FSM.
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        wr_nxt_s     = wr_r;
        cen_nxt_s    = cen_r;
        addr_nxt_s   = addr_r;
        wdata_nxt_s  = wdata_r;
        streak_nxt_s = streak_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_data_s) begin
                    owner_nxt_s  = OWNER_DATA;
                    wr_nxt_s     = data_wr;
                    cen_nxt_s    = data_cen;
                    addr_nxt_s   = data_addr;
                    wdata_nxt_s  = data_wdata;
                    streak_nxt_s = next_streak(streak_r, 1'b1, inst_req);
                    state_nxt_s  = ST_ISSUE;
                end else if (grant_inst_s) begin
                    owner_nxt_s  = OWNER_INST;
                    wr_nxt_s     = inst_wr;
                    cen_nxt_s    = inst_cen;
                    addr_nxt_s   = inst_addr;
                    wdata_nxt_s  = inst_wdata;
                    streak_nxt_s = next_streak(streak_r, 1'b0, inst_req);
                    state_nxt_s  = ST_ISSUE;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (sram_ack) begin
                    if (wr_r) begin
                        state_nxt_s = ST_IDLE;
                    end else if (sram_rrdy) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT_RD;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT_RD: begin
                if (sram_rrdy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_RD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_r  <= ST_IDLE;
            owner_r  <= OWNER_INST;
            wr_r     <= 1'b0;
            cen_r    <= 4'hF;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            streak_r <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            owner_r  <= owner_nxt_s;
            wr_r     <= wr_nxt_s;
            cen_r    <= cen_nxt_s;
            addr_r   <= addr_nxt_s;
            wdata_r  <= wdata_nxt_s;
            streak_r <= streak_nxt_s;
        end
    end

    // Handshake qualification: SRAM responses only count in the states that expect them.
    always_comb begin
        ack_s  = 1'b0;
        rrdy_s = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                ack_s  = sram_ack;
                rrdy_s = sram_ack && !wr_r && sram_rrdy;
            end
            ST_WAIT_RD: begin
                ack_s  = 1'b0;
                rrdy_s = sram_rrdy;
            end
            default: begin
                ack_s  = 1'b0;
                rrdy_s = 1'b0;
            end
        endcase
    end

    // Route handshakes to the owner and drive the shared port from the latched request.
    always_comb begin
        inst_ack   = ack_s && (owner_r == OWNER_INST);
        data_ack   = ack_s && (owner_r == OWNER_DATA);
        inst_rrdy  = rrdy_s && (owner_r == OWNER_INST);
        data_rrdy  = rrdy_s && (owner_r == OWNER_DATA);
        inst_rdata = sram_rdata;
        data_rdata = sram_rdata;
        if (state_r == ST_ISSUE) begin
            sram_cen = cen_r;
            sram_wr  = wr_r;
        end else begin
            sram_cen = 4'hF;
            sram_wr  = 1'b0;
        end
        sram_addr  = addr_r;
        sram_wdata = wdata_r;
        arb_busy   = (state_r != ST_IDLE);
        arb_owner  = owner_r;
    end

endmodule

// File: doc/fairy_sram_arbiter.md
# fairy_sram_arbiter

Shares one external SRAM port between the CPU's instruction-fetch and data-memory requesters. It sits between the fetch/mem stages and a unified memory, and runs a single-outstanding-transaction FSM. Data requests have priority, and a streak counter prevents fetch starvation. Shared-port signalling uses the existing sram conventions: cen active-low per-byte, wr=1 for write, ack = request accepted, rrdy = read data valid.

## Interface
- DATA_MAX_STREAK, 4, max consecutive data grants while inst_req is pending (legal 1..15)
- aclk  in  1  clock
- areset_n  in  1  reset, synchronous, active-low
- inst_req / data_req  in  1  request valid; held stable by requester until its *_ack
- inst_wr / data_wr  in  1  1=write, 0=read
- inst_cen / data_cen  in  4  byte enables, active-low
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data
- inst_ack / data_ack  out  1  request accepted by SRAM (combinational)
- inst_rrdy / data_rrdy  out  1  read data valid (combinational)
- inst_rdata / data_rdata  out  32  read data, equals sram_rdata
- sram_cen  out  4  shared byte enables; 4'hF when idle
- sram_wr  out  1  shared write strobe
- sram_addr  out  32  shared address
- sram_wdata  out  32  shared write data
- sram_ack  in  1  SRAM accepted request
- sram_rrdy  in  1  SRAM read data valid
- sram_rdata  in  32  SRAM read data
- arb_busy  out  1  state != IDLE
- arb_owner  out  1  0=inst, 1=data; valid while arb_busy

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- IDLE: if any req, select an owner and latch its wr/cen/addr/wdata into registers, then go to ISSUE. With no req, stay in IDLE.
- Selection: data wins. Exception: if streak == DATA_MAX_STREAK and inst_req=1, inst wins.
- streak: 4-bit counter.
  - +1 on a data grant while inst_req=1.
  - Cleared on an inst grant.
  - Cleared on a data grant when inst_req=0.
  - Saturates at DATA_MAX_STREAK.
- ISSUE: drive the latched request on sram_*. On sram_ack, pulse owner *_ack that same cycle. Next state:
  - write → IDLE.
  - read with sram_rrdy=1 in the same cycle → pulse owner *_rrdy too, then IDLE.
  - read with sram_rrdy=0 → WAIT_RD.
- WAIT_RD: sram_cen=4'hF, sram_wr=0. On sram_rrdy, pulse owner *_rrdy and go to IDLE.
- Gating:
  - *_ack is raised only in ISSUE and only for the owner.
  - *_rrdy is raised only in the ISSUE read fast path or in WAIT_RD, and only for the owner.
  - sram_ack/sram_rrdy arriving in any other state are ignored.
- Requests arriving in a non-IDLE state are not sampled. The requester keeps req high and is served later.
- *_rdata are always sram_rdata. They are meaningful only with *_rrdy.

## Timing
- Reset values (cycle after areset_n sampled low):
  - State: IDLE.
  - Shared port: sram_cen=4'hF, sram_wr=0, sram_addr=0, sram_wdata=0.
  - Control: streak=0, arb_owner=0, arb_busy=0.
  - All *_ack/*_rrdy: 0.
- Reset mid-transaction abandons it. A late sram_ack/sram_rrdy arriving after reset produces no *_ack/*_rrdy.
- Grant latency: req sampled in IDLE at cycle N; sram_* driven from N+1.
- Zero-wait write: ack at N+1, back to IDLE at N+2. Back-to-back throughput is one request per 2 cycles.
- Zero-wait read (ack and rrdy both at N+1): same 2-cycle throughput.
- Read with rrdy k cycles after ack: IDLE at ack cycle + k + 1.
- sram_* stay constant from ISSUE entry until sram_ack. ISSUE with no sram_ack holds indefinitely; there is no timeout.
- Requester may drop or change req in the cycle after its *_ack. The arbiter's next IDLE sample must not re-grant a request that was already acknowledged.

## Test plan
- Reset: hold areset_n=0 for 2 cycles with both reqs high → sram_cen=4'hF, no ack; first grant 1 cycle after release goes to data.
- Zero-wait write on data (addr 0x100, wdata 0xDEADBEEF, cen 4'b0000) → sram_wr=1 at N+1; data_ack=1 at N+1; arb_busy=0 at N+2.
- Read on inst, sram_rrdy 3 cycles after sram_ack, rdata 0x24080001 → inst_ack once; inst_rrdy once with inst_rdata=0x24080001; data_rrdy stays 0.
- Starvation, DATA_MAX_STREAK=4, both reqs continuously high → grant order D,D,D,D,I,D,D,D,D,I…
- Spurious sram_rrdy while IDLE, and sram_ack while in WAIT_RD → no *_ack/*_rrdy pulses; state unchanged.
- Reset asserted during WAIT_RD, sram_rrdy arrives 1 cycle after release → no *_rrdy pulse; next pending req is granted normally.
